fir_channel_scheduler: RTL and testbench

Time-multiplexes one multi-channel FIR filter core among NUM_CH independent sample streams. It arbitrates per-channel input requests round-robin, issues one tagged sample per cycle to the core, and tracks in-flight channel tags through the core's fixed latency. It routes each filtered result back to the owning channel and sequences enable/drain from the FIR_Filter AXI4-Lite control register.

---
 rtl/fir_sched_pkg.sv | 20 ++
 rtl/fir_rr_arbiter.sv | 45 ++++
 rtl/fir_channel_scheduler.sv | 142 ++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types for the FIR channel scheduler: FSM states, tag-pipeline entry
// and the width of the optional grant counters.
package fir_sched_pkg;

  localparam int CNT_W    = 16;
  // Channel field sized for the largest supported channel count (16).
  localparam int TAG_CH_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer, with wrap.
// Pointer advances past the winner and holds when nothing is granted.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_vld
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_cand;

  // Scan a doubled index range so the wrap needs no modulo on the pointer.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < 2*NUM_CH; k++) begin
      w_cand = CH_W'(k % NUM_CH);
      if (i_en && !o_vld && k >= int'(r_ptr) && k < int'(r_ptr) + NUM_CH
          && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
    o_gnt = o_vld ? (NUM_CH'(1) << o_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_vld) begin
      r_ptr <= (o_idx == CH_W'(NUM_CH-1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR core among NUM_CH streams: arbitrates, issues tagged samples,
// tracks tags through the core latency and returns results per channel.
// Optional per-channel grant counters are built when FIR_SCHED_STATS_EN is defined.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 32,
  parameter  int FIR_LATENCY = 8,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0]        s_ready,
  output logic                     fir_valid,
  output logic [CH_W-1:0]          fir_ch,
  output logic [DATA_W-1:0]        fir_data,
  input  logic                     fir_out_valid,
  input  logic [DATA_W-1:0]        fir_out_data,
  output logic [NUM_CH-1:0]        m_valid,
  output logic [DATA_W-1:0]        m_data,
  output logic                     idle,
  output logic                     error
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  grant_cnt
`endif
);

  state_e              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   w_gnt;
  logic [CH_W-1:0]     w_idx;
  logic                w_hs;
  logic                r_fir_valid;
  logic [CH_W-1:0]     r_fir_ch;
  logic [DATA_W-1:0]   r_fir_data;
  tag_t                r_tag [FIR_LATENCY];
  tag_t                w_tail;
  logic                w_pipe_busy;
  logic [NUM_CH-1:0]   r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_error;

  fir_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .clk   (ACLK),
    .rst   (ARESET),
    .i_en  (r_state == RUN),
    .i_req (s_valid),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_hs)
  );

  assign s_ready   = w_gnt;
  assign fir_valid = r_fir_valid;
  assign fir_ch    = r_fir_ch;
  assign fir_data  = r_fir_data;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign error     = r_error;
  assign w_tail    = r_tag[FIR_LATENCY-1];

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < FIR_LATENCY; i++) w_pipe_busy = w_pipe_busy | r_tag[i].valid;
  end

  // DRAIN ignores enable so every issued sample is returned before IDLE.
  always_comb begin
    w_state_nxt = r_state;
    idle        = (r_state == IDLE);
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = DRAIN;
      DRAIN:   if (!w_pipe_busy && !r_fir_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_fir_valid <= 1'b0;
      r_fir_ch    <= '0;
      r_fir_data  <= '0;
    end else begin
      r_fir_valid <= w_hs;
      if (w_hs) begin
        r_fir_ch   <= w_idx;
        r_fir_data <= s_data[w_idx*DATA_W +: DATA_W];
      end
    end
  end

  // Tag tail lines up with the core's result for the same sample.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < FIR_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_fir_valid, ch: TAG_CH_W'(r_fir_ch)};
      for (int i = 1; i < FIR_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_m_valid <= '0;
      r_m_data  <= '0;
      r_error   <= 1'b0;
    end else begin
      r_m_valid <= '0;
      if (fir_out_valid && w_tail.valid) begin
        r_m_valid <= NUM_CH'(1) << w_tail.ch;
        r_m_data  <= fir_out_data;
      end
      if (fir_out_valid != w_tail.valid) r_error <= 1'b1;
    end
  end

`ifdef FIR_SCHED_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_gnt[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler with an echoing FIR core model.
module tb_fir_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int LAT    = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  logic                     ACLK = 1'b0;
  logic                     ARESET = 1'b1;
  logic                     enable = 1'b0;
  logic [NUM_CH-1:0]        s_valid = '0;
  logic [NUM_CH*DATA_W-1:0] s_data = '0;
  logic [NUM_CH-1:0]        s_ready;
  logic                     fir_valid;
  logic [CH_W-1:0]          fir_ch;
  logic [DATA_W-1:0]        fir_data;
  logic                     fir_out_valid;
  logic [DATA_W-1:0]        fir_out_data;
  logic [NUM_CH-1:0]        m_valid;
  logic [DATA_W-1:0]        m_data;
  logic                     idle;
  logic                     error;
`ifdef FIR_SCHED_STATS_EN
  logic [NUM_CH*16-1:0]     grant_cnt;
`endif

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIR_LATENCY(LAT)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .fir_valid     (fir_valid),
    .fir_ch        (fir_ch),
    .fir_data      (fir_data),
    .fir_out_valid (fir_out_valid),
    .fir_out_data  (fir_out_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .idle          (idle),
    .error         (error)
`ifdef FIR_SCHED_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Core model: echoes each issued sample LAT cycles later; inj forces a stray result.
  logic [LAT-1:0]    core_v;
  logic [DATA_W-1:0] core_d [LAT];
  logic              inj = 1'b0;
  always @(posedge ACLK) begin
    if (ARESET) begin
      core_v <= '0;
      for (int i = 0; i < LAT; i++) core_d[i] <= '0;
    end else begin
      core_v    <= {core_v[LAT-2:0], fir_valid};
      core_d[0] <= fir_data;
      for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
    end
  end
  assign fir_out_valid = core_v[LAT-1] | inj;
  assign fir_out_data  = core_d[LAT-1];

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] d;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arbitration state
  int                tb_ptr = 0;
  int                tb_cnt [NUM_CH];
  logic              p_v = 1'b0;
  int                p_ch = 0;
  logic [DATA_W-1:0] p_d = '0;

  // One cycle of stimulus; run says whether the DUT is expected in RUN this cycle.
  task automatic cyc_drive(input logic [NUM_CH-1:0] v, input logic en, input logic run);
    int gi;
    logic [NUM_CH-1:0] g;
    @(negedge ACLK);
    chk("fir_valid", 64'(fir_valid), 64'(p_v));
    if (p_v) begin
      chk("fir_ch", 64'(fir_ch), 64'(p_ch));
      chk("fir_data", 64'(fir_data), 64'(p_d));
    end
    enable  = en;
    s_valid = v;
    for (int i = 0; i < NUM_CH; i++) s_data[i*DATA_W +: DATA_W] = $urandom;
    #1;
    gi = -1;
    if (run)
      for (int k = 0; k < NUM_CH; k++)
        if (gi < 0 && v[(tb_ptr+k)%NUM_CH]) gi = (tb_ptr + k) % NUM_CH;
    g = (gi >= 0) ? (NUM_CH'(1) << gi) : '0;
    chk("s_ready", 64'(s_ready), 64'(g));
    p_v = (gi >= 0);
    if (gi >= 0) begin
      p_ch = gi;
      p_d  = s_data[gi*DATA_W +: DATA_W];
      q.push_back('{ch: gi, d: p_d, cyc: cyc + 2 + LAT});
      tb_ptr = (gi + 1) % NUM_CH;
      tb_cnt[gi]++;
    end
  endtask

  task automatic wait_drain(input logic en);
    for (int n = 0; n < 40 && q.size() > 0; n++) cyc_drive('0, en, 1'b0);
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_cnt();
`ifdef FIR_SCHED_STATS_EN
    for (int i = 0; i < NUM_CH; i++)
      chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(tb_cnt[i]));
`endif
  endtask

  // Result monitor: samples shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge ACLK);
      #3;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("m_late", 64'(q[0].cyc), 64'(cyc));
        void'(q.pop_front());
      end
      if (m_valid != '0) begin
        if (q.size() == 0) chk("m_spurious", 64'(m_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("m_cyc", 64'(cyc), 64'(e.cyc));
          chk("m_valid", 64'(m_valid), 64'(NUM_CH'(1) << e.ch));
          chk("m_data", 64'(m_data), 64'(e.d));
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("m_missing", 64'(m_valid), 64'(NUM_CH'(1) << q[0].ch));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int t5;
    for (int i = 0; i < NUM_CH; i++) tb_cnt[i] = 0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_fir_valid", 64'(fir_valid), 64'd0);
    chk("rst_fir_ch", 64'(fir_ch), 64'd0);
    chk("rst_fir_data", 64'(fir_data), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk_cnt();
    ARESET = 1'b0;

    // Single channel
    cyc_drive('0, 1'b1, 1'b0);
    chk("idle_before_run", 64'(idle), 64'd1);
    cyc_drive(4'b0001, 1'b1, 1'b1);
    chk("idle_in_run", 64'(idle), 64'd0);
    wait_drain(1'b1);

    // Contention
    repeat (8) cyc_drive(4'b1111, 1'b1, 1'b1);
    cyc_drive('0, 1'b1, 1'b1);
    chk_cnt();
    wait_drain(1'b1);

    // Fairness with gaps
    repeat (8) cyc_drive(4'b1010, 1'b1, 1'b1);
    wait_drain(1'b1);

    // Drain: enable drops on the 5th handshake, re-asserts mid-drain
    repeat (4) cyc_drive(4'b1111, 1'b1, 1'b1);
    cyc_drive(4'b1111, 1'b0, 1'b1);
    t5 = cyc;
    while (cyc < t5 + 3 + LAT) begin
      cyc_drive(4'b1111, (cyc >= t5 + 2), 1'b0);
      chk("drain_idle", 64'(idle), 64'(cyc == t5 + 3 + LAT));
    end
    cyc_drive(4'b1111, 1'b1, 1'b1);
    chk("rerun_idle", 64'(idle), 64'd0);
    cyc_drive('0, 1'b0, 1'b1);
    wait_drain(1'b0);
    repeat (3) cyc_drive('0, 1'b0, 1'b0);
    chk_cnt();

    // Mismatch: stray core result with an empty tag pipeline
    chk("mm_idle", 64'(idle), 64'd1);
    chk("mm_err_pre", 64'(error), 64'd0);
    inj = 1'b1;
    cyc_drive('0, 1'b0, 1'b0);
    inj = 1'b0;
    chk("mm_error", 64'(error), 64'd1);
    chk("mm_m_valid", 64'(m_valid), 64'd0);
    repeat (3) cyc_drive('0, 1'b0, 1'b0);
    chk("mm_sticky", 64'(error), 64'd1);

    // Reset during full traffic
    cyc_drive('0, 1'b1, 1'b0);
    repeat (6) cyc_drive(4'b1111, 1'b1, 1'b1);
    @(negedge ACLK);
    ARESET = 1'b1;
    s_valid = 4'b1111;
    q.delete();
    p_v = 1'b0;
    tb_ptr = 0;
    for (int i = 0; i < NUM_CH; i++) tb_cnt[i] = 0;
    @(negedge ACLK);
    chk("mr_idle", 64'(idle), 64'd1);
    chk("mr_s_ready", 64'(s_ready), 64'd0);
    chk("mr_fir_valid", 64'(fir_valid), 64'd0);
    chk("mr_fir_ch", 64'(fir_ch), 64'd0);
    chk("mr_fir_data", 64'(fir_data), 64'd0);
    chk("mr_m_valid", 64'(m_valid), 64'd0);
    chk("mr_m_data", 64'(m_data), 64'd0);
    chk("mr_error", 64'(error), 64'd0);
    chk_cnt();
    ARESET = 1'b0;
    repeat (5) cyc_drive(4'b1111, 1'b1, 1'b1);
    cyc_drive('0, 1'b0, 1'b1);
    wait_drain(1'b0);
    repeat (3) cyc_drive('0, 1'b0, 1'b0);
    chk("end_idle", 64'(idle), 64'd1);
    chk("end_error", 64'(error), 64'd0);
    chk_cnt();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
